// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: entry layout, tag/index typedefs and sizing constants.
package rob_pkg;

  localparam int unsigned ROB_WIDTH  = 5;
  localparam int unsigned PHY_WIDTH  = 6;
  localparam int unsigned ARCH_WIDTH = 5;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned SID_WIDTH  = 4;
  localparam int unsigned ROB_DEPTH  = 2 ** ROB_WIDTH;
  localparam int unsigned CNT_WIDTH  = ROB_WIDTH + 1;

  typedef logic [ROB_WIDTH-1:0]  rob_id_t;
  typedef logic [PHY_WIDTH-1:0]  phy_t;
  typedef logic [ARCH_WIDTH-1:0] arch_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [SID_WIDTH-1:0]  sid_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  typedef struct packed {
    logic  valid;
    logic  done;
    logic  has_rd;
    arch_t rd_arch;
    phy_t  rd_phy;
    phy_t  old_phy;
    logic  is_store;
    sid_t  store_id;
    logic  mispredict;
    addr_t target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retire signal bundle of the reorder buffer.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic    alloc_valid;
  logic    alloc_ready;
  rob_id_t alloc_rob_id;
  logic    alloc_has_rd;
  arch_t   alloc_rd_arch;
  phy_t    alloc_rd_phy;
  phy_t    alloc_old_phy;
  logic    alloc_is_store;

  logic    alu_valid;
  rob_id_t alu_rob_id;
  logic    load_valid;
  rob_id_t load_rob_id;
  logic    store_valid;
  rob_id_t store_rob_id;
  sid_t    store_id;
  logic    branch_valid;
  rob_id_t branch_rob_id;
  logic    mispredict;
  addr_t   actual_target;

  logic    retire_valid;
  logic    retire_has_rd;
  arch_t   retire_rd_arch;
  phy_t    retire_rd_phy;
  phy_t    retire_old_phy;
  logic    retire_store_valid;
  sid_t    retire_store_id;
  logic    flush_out;
  addr_t   flush_pc;

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_rd_arch, alloc_rd_phy, alloc_old_phy, alloc_is_store,
    input  alu_valid, alu_rob_id, load_valid, load_rob_id,
    input  store_valid, store_rob_id, store_id,
    input  branch_valid, branch_rob_id, mispredict, actual_target,
    output alloc_ready, alloc_rob_id,
    output retire_valid, retire_has_rd, retire_rd_arch, retire_rd_phy, retire_old_phy,
    output retire_store_valid, retire_store_id, flush_out, flush_pc
  );

  modport master (
    output alloc_valid, alloc_has_rd, alloc_rd_arch, alloc_rd_phy, alloc_old_phy, alloc_is_store,
    output alu_valid, alu_rob_id, load_valid, load_rob_id,
    output store_valid, store_rob_id, store_id,
    output branch_valid, branch_rob_id, mispredict, actual_target,
    input  alloc_ready, alloc_rob_id,
    input  retire_valid, retire_has_rd, retire_rd_arch, retire_rd_phy, retire_old_phy,
    input  retire_store_valid, retire_store_id, flush_out, flush_pc
  );

endinterface

// File: rtl/rob_retire_ctrl.sv
// Turns the head entry into commit, store-release and flush signals (purely combinational).
module rob_retire_ctrl
  import rob_pkg::*;
(
  input  rob_entry_t head_entry_i,
  output logic       retire_valid_o,
  output logic       retire_has_rd_o,
  output arch_t      retire_rd_arch_o,
  output phy_t       retire_rd_phy_o,
  output phy_t       retire_old_phy_o,
  output logic       retire_store_valid_o,
  output sid_t       retire_store_id_o,
  output logic       flush_o,
  output addr_t      flush_pc_o
);

  logic ready;

  assign ready                = head_entry_i.valid && head_entry_i.done;
  assign retire_valid_o       = ready;
  assign retire_has_rd_o      = ready && head_entry_i.has_rd;
  assign retire_rd_arch_o     = head_entry_i.rd_arch;
  assign retire_rd_phy_o      = head_entry_i.rd_phy;
  assign retire_old_phy_o     = head_entry_i.old_phy;
  assign retire_store_valid_o = ready && head_entry_i.is_store;
  assign retire_store_id_o    = head_entry_i.store_id;
  assign flush_o              = ready && head_entry_i.mispredict;
  assign flush_pc_o           = head_entry_i.target;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order ROB: allocate at tail, complete from writeback, retire one per cycle from head.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  bus
);

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];
  rob_id_t    head_q, head_d;
  rob_id_t    tail_q, tail_d;
  cnt_t       count_q, count_d;

  rob_entry_t head_entry;
  rob_entry_t new_entry;
  logic       alloc_ready;
  logic       alloc_fire;
  logic       retire_fire;
  logic       flush;

  assign head_entry = entries_q[head_q];

  rob_retire_ctrl u_retire_ctrl (
    .head_entry_i         (head_entry),
    .retire_valid_o       (retire_fire),
    .retire_has_rd_o      (bus.retire_has_rd),
    .retire_rd_arch_o     (bus.retire_rd_arch),
    .retire_rd_phy_o      (bus.retire_rd_phy),
    .retire_old_phy_o     (bus.retire_old_phy),
    .retire_store_valid_o (bus.retire_store_valid),
    .retire_store_id_o    (bus.retire_store_id),
    .flush_o              (flush),
    .flush_pc_o           (bus.flush_pc)
  );

  // Allocation is refused while full or while the head is flushing the pipe.
  assign alloc_ready      = (count_q != CNT_WIDTH'(ROB_DEPTH)) && !flush;
  assign alloc_fire       = bus.alloc_valid && alloc_ready;
  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_rob_id = tail_q;
  assign bus.retire_valid = retire_fire;
  assign bus.flush_out    = flush;

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.has_rd     = bus.alloc_has_rd;
    new_entry.rd_arch    = bus.alloc_rd_arch;
    new_entry.rd_phy     = bus.alloc_rd_phy;
    new_entry.old_phy    = bus.alloc_old_phy;
    new_entry.is_store   = bus.alloc_is_store;
  end

  // Next-state: completions qualify on the pre-edge valid bit, so the entry
  // being allocated this cycle cannot be completed in the same cycle.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + CNT_WIDTH'(alloc_fire) - CNT_WIDTH'(retire_fire);

    if (alloc_fire) begin
      entries_d[tail_q] = new_entry;
      tail_d            = tail_q + ROB_WIDTH'(1);
    end

    if (bus.alu_valid && entries_q[bus.alu_rob_id].valid) begin
      entries_d[bus.alu_rob_id].done = 1'b1;
    end
    if (bus.load_valid && entries_q[bus.load_rob_id].valid) begin
      entries_d[bus.load_rob_id].done = 1'b1;
    end
    if (bus.store_valid && entries_q[bus.store_rob_id].valid) begin
      entries_d[bus.store_rob_id].done     = 1'b1;
      entries_d[bus.store_rob_id].store_id = bus.store_id;
    end
    if (bus.branch_valid && entries_q[bus.branch_rob_id].valid) begin
      entries_d[bus.branch_rob_id].done = 1'b1;
      if (bus.mispredict) begin
        entries_d[bus.branch_rob_id].mispredict = 1'b1;
        entries_d[bus.branch_rob_id].target     = bus.actual_target;
      end
    end

    if (retire_fire) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + ROB_WIDTH'(1);
    end

    if (flush) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
